acc_sat_scale: RTL and testbench

Parametrised successor to the FIR output saturator. Takes signed accumulator samples from the multichannel FIR MAC, arithmetic-right-shifts them by a runtime-programmable amount, optionally rounds, and saturates to a signed OUT_W result. Two-stage valid/ready pipeline at full throughput; keeps per-channel sticky saturation flags and a saturation event counter for the CSR block. Sits between the FIR MAC accumulator and the downstream sample FIFO.

---
 rtl/fir_pkg.sv | 14 +
 rtl/acc_sat_scale_if.sv | 33 +++
 rtl/sat_clip.sv | 32 +++
 rtl/acc_sat_scale.sv | 110 +++++++++++
 tb/tb_acc_sat_scale.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types for the FIR output path: saturation codes and channel-width helper.
package fir_pkg;

    typedef logic [1:0] sat_t;

    localparam sat_t SAT_NONE = 2'b00;
    localparam sat_t SAT_POS  = 2'b10;
    localparam sat_t SAT_NEG  = 2'b01;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_sat_scale_if.sv
// Sample stream bus between the FIR MAC, the scaler and the downstream FIFO.
interface acc_sat_scale_if #(
    parameter int IN_W  = 29,
    parameter int OUT_W = 16,
    parameter int N_CH  = 2
) ();
    import fir_pkg::*;

    localparam int CH_W = ch_width(N_CH);
    localparam int SH_W = $clog2(IN_W);

    logic              in_vld;
    logic              in_rdy;
    logic [IN_W-1:0]   in_data;
    logic [CH_W-1:0]   in_ch;
    logic [SH_W-1:0]   shift;
    logic              rnd_en;
    logic              out_vld;
    logic              out_rdy;
    logic [OUT_W-1:0]  out_data;
    logic [CH_W-1:0]   out_ch;
    sat_t              out_sat;

    modport master (
        output in_vld, in_data, in_ch, shift, rnd_en, out_rdy,
        input  in_rdy, out_vld, out_data, out_ch, out_sat
    );

    modport slave (
        input  in_vld, in_data, in_ch, shift, rnd_en, out_rdy,
        output in_rdy, out_vld, out_data, out_ch, out_sat
    );
endinterface

// File: rtl/sat_clip.sv
// Signed IN_W -> OUT_W clip with saturation code; purely combinational.
module sat_clip
    import fir_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0] din,
    output logic [OUT_W-1:0]       dout,
    output sat_t                   sat
);
    // Value fits iff every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] hi;
    logic                fits;

    assign hi   = din[IN_W-1:OUT_W-1];
    assign fits = (&hi) | ~(|hi);

    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = SAT_NONE;
        if (!fits) begin
            if (din[IN_W-1]) begin
                sat  = SAT_NEG;
                dout = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                sat  = SAT_POS;
                dout = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end
endmodule

// File: rtl/acc_sat_scale.sv
// Accumulator scaler: shift/round in stage 1, saturate in stage 2, plus saturation stats.
module acc_sat_scale
    import fir_pkg::*;
#(
    parameter int IN_W  = 29,
    parameter int OUT_W = 16,
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    acc_sat_scale_if.slave     bus,
    input  logic               clr_stats,
    output logic [N_CH-1:0]    sat_sticky,
    output logic [CNT_W-1:0]   sat_cnt
);
    localparam int CH_W   = ch_width(N_CH);
    localparam int SH_W   = $clog2(IN_W);
    localparam int SH_MAX = IN_W - 1;

    typedef struct packed {
        logic [OUT_W-1:0] value;
        logic [CH_W-1:0]  ch;
        sat_t             sat;
    } stage_t;

    logic [2:1]           vld_pipe;
    logic signed [IN_W:0] s1_value;
    logic [CH_W-1:0]      s1_ch;
    stage_t               s2;
    logic                 s1_en, s2_en;

    assign s2_en      = !vld_pipe[2] || bus.out_rdy;
    assign s1_en      = !vld_pipe[1] || s2_en;
    assign bus.in_rdy = s1_en;

    // One extra headroom bit keeps the rounding add from overflowing.
    logic [SH_W-1:0]      sh;
    logic signed [IN_W:0] ext, rnd_add, scaled;

    always_comb begin
        sh      = (32'(bus.shift) >= IN_W) ? SH_W'(SH_MAX) : bus.shift;
        ext     = {bus.in_data[IN_W-1], bus.in_data};
        rnd_add = '0;
        if (bus.rnd_en && sh != '0)
            rnd_add[sh - SH_W'(1)] = 1'b1;
        scaled  = (ext + rnd_add) >>> sh;
    end

    logic [OUT_W-1:0] clip_data;
    sat_t             clip_sat;

    sat_clip #(.IN_W(IN_W + 1), .OUT_W(OUT_W)) u_clip (
        .din  (s1_value),
        .dout (clip_data),
        .sat  (clip_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_value <= '0;
            s1_ch    <= '0;
            s2       <= '0;
        end else begin
            if (s1_en) begin
                vld_pipe[1] <= bus.in_vld;
                if (bus.in_vld) begin
                    s1_value <= scaled;
                    s1_ch    <= bus.in_ch;
                end
            end
            if (s2_en) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1])
                    s2 <= '{value: clip_data, ch: s1_ch, sat: clip_sat};
            end
        end
    end

    assign bus.out_vld  = vld_pipe[2];
    assign bus.out_data = s2.value;
    assign bus.out_ch   = s2.ch;
    assign bus.out_sat  = s2.sat;

    logic sat_hs;
    assign sat_hs = vld_pipe[2] && bus.out_rdy && (s2.sat != SAT_NONE);

    // Clear is applied first so a same-cycle saturating delivery still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= '0;
            sat_cnt    <= '0;
        end else begin
            if (clr_stats) begin
                sat_sticky <= '0;
                sat_cnt    <= '0;
            end
            if (sat_hs) begin
                for (int i = 0; i < N_CH; i++)
                    if (s2.ch == CH_W'(i))
                        sat_sticky[i] <= 1'b1;
                if (clr_stats)
                    sat_cnt <= CNT_W'(1);
                else if (sat_cnt != '1)
                    sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_acc_sat_scale.sv
// Directed + random bench for acc_sat_scale against an arithmetic reference model.
module tb_acc_sat_scale;
    localparam int IN_W  = 29;
    localparam int OUT_W = 16;
    localparam int N_CH  = 2;
    localparam int CNT_W = 4;
    localparam int SH_W  = $clog2(IN_W);
    localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MINV = -(MAXV + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic clr_stats;
    logic [N_CH-1:0]  sat_sticky;
    logic [CNT_W-1:0] sat_cnt;

    always #5 clk = ~clk;

    acc_sat_scale_if #(.IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH)) bus ();

    acc_sat_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_stats  (clr_stats),
        .sat_sticky (sat_sticky),
        .sat_cnt    (sat_cnt)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             ch;
        logic [1:0]       sat;
        int               acc;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0, last_stall = -1;
    int m_cnt = 0;
    logic [N_CH-1:0] m_sticky = '0;
    logic held = 1'b0, last_ih = 1'b0;
    logic [OUT_W-1:0] h_data;
    logic h_ch;
    logic [1:0] h_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor((x + half) / 2^s) then clamp to the signed output range.
    function automatic exp_t model(input longint d, input int sh, input bit rnd,
                                   input logic ch, input int acc);
        exp_t e;
        int s;
        longint v;
        s = (sh > IN_W - 1) ? IN_W - 1 : sh;
        v = d;
        if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        e.ch  = ch;
        e.acc = acc;
        if (v > MAXV) begin
            e.data = OUT_W'(MAXV); e.sat = 2'b10;
        end else if (v < MINV) begin
            e.data = OUT_W'(MINV); e.sat = 2'b01;
        end else begin
            e.data = OUT_W'(v);    e.sat = 2'b00;
        end
        return e;
    endfunction

    task automatic drive(input bit v, input longint d, input int sh, input bit rnd, input bit ch);
        bus.in_vld  = v;
        bus.in_data = IN_W'(d);
        bus.shift   = SH_W'(sh);
        bus.rnd_en  = rnd;
        bus.in_ch   = ch;
    endtask

    task automatic tick();
        exp_t e;
        logic ih, oh, exp_rdy;
        #1;
        exp_rdy = (q.size() < 2) || bus.out_rdy;
        if (!rst) chk("in_rdy", bus.in_rdy, exp_rdy);
        if (!rst && held) begin
            chk("hold_vld",  bus.out_vld,  1);
            chk("hold_data", bus.out_data, h_data);
            chk("hold_ch",   bus.out_ch,   h_ch);
            chk("hold_sat",  bus.out_sat,  h_sat);
        end
        ih = bus.in_vld && bus.in_rdy && !rst;
        oh = bus.out_vld && bus.out_rdy && !rst;
        if (!rst && clr_stats) begin m_cnt = 0; m_sticky = '0; end
        if (oh) begin
            if (q.size() == 0) chk("out_vld_empty", bus.out_vld, 0);
            else begin
                e = q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_ch",   bus.out_ch,   e.ch);
                chk("out_sat",  bus.out_sat,  e.sat);
                if (last_stall < e.acc) chk("latency", cyc - e.acc, 2);
                if (e.sat != 2'b00) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_sticky[e.ch] = 1'b1;
                end
            end
        end
        held   = !rst && bus.out_vld && !bus.out_rdy;
        h_data = bus.out_data;
        h_ch   = bus.out_ch;
        h_sat  = bus.out_sat;
        if (!bus.out_rdy) last_stall = cyc;
        if (ih) q.push_back(model(longint'($signed(bus.in_data)), int'(bus.shift),
                                  bus.rnd_en, bus.in_ch, cyc));
        last_ih = ih;
        @(posedge clk);
        cyc++;
        if (rst) begin q.delete(); m_cnt = 0; m_sticky = '0; held = 1'b0; end
        #1;
        chk("sat_cnt",    sat_cnt,    m_cnt);
        chk("sat_sticky", sat_sticky, m_sticky);
    endtask

    task automatic send(input longint d, input int sh, input bit rnd, input bit ch);
        drive(1'b1, d, sh, rnd, ch);
        tick();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [IN_W-1:0] r;
        int sent;
        rst = 1'b1;
        clr_stats = 1'b0;
        bus.out_rdy = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_rdy",   bus.in_rdy,   1);
        chk("rst_out_vld",  bus.out_vld,  0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ch",   bus.out_ch,   0);
        chk("rst_out_sat",  bus.out_sat,  0);

        // rounding, clipping and boundary cases
        send('h12345, 10, 1'b1, 1'b0);
        send('h12345, 10, 1'b0, 1'b1);
        idle(3);
        send('h4000000, 10, 1'b0, 1'b0);
        send(-'h4000000, 10, 1'b0, 1'b1);
        idle(3);
        send('h1FFFE00, 10, 1'b1, 1'b0);
        send('h1FFFE00, 10, 1'b0, 1'b1);
        send('h0FFFFFF, 31, 1'b0, 1'b0);
        send(-'h1000, 31, 1'b0, 1'b1);
        send(-'h0C00, 11, 1'b1, 1'b0);
        idle(3);

        // counter saturates at all-ones
        for (int i = 0; i < 20; i++) send('h4000000, 10, 1'b0, i[0]);
        idle(3);
        chk("cnt_hold", sat_cnt, CNT_MAX);

        // clear coinciding with a saturating delivery
        send('h4000000, 10, 1'b0, 1'b1);
        idle(1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_hs_cnt", sat_cnt, 1);
        chk("clr_hs_sticky", sat_sticky, 2'b10);
        idle(2);

        // six-sample stream with a five-cycle downstream stall
        sent = 0;
        for (int k = 0; k < 18; k++) begin
            bus.out_rdy = !(k >= 3 && k < 8);
            if (sent < 6) drive(1'b1, 1000 * (sent + 1) + 7, 0, 1'b0, sent[0]);
            else drive(1'b0, 0, 0, 1'b0, 1'b0);
            tick();
            if (last_ih) sent++;
        end
        chk("bp_sent", sent, 6);
        chk("bp_drained", q.size(), 0);

        // randomized traffic with random backpressure and occasional clears
        for (int k = 0; k < 400; k++) begin
            r = IN_W'($urandom);
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            clr_stats   = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0, longint'($signed(r)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(8, 14),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            tick();
        end
        clr_stats = 1'b0;
        bus.out_rdy = 1'b1;
        idle(4);
        chk("rand_drained", q.size(), 0);

        // reset with both stages full
        bus.out_rdy = 1'b0;
        send('h4000000, 10, 1'b0, 1'b0);
        send(-'h4000000, 10, 1'b0, 1'b1);
        send('h4000000, 10, 1'b0, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_vld", bus.out_vld, 0);
        chk("mid_rst_cnt", sat_cnt, 0);
        bus.out_rdy = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
